fft_band_accum: RTL
===================

// Module: fft_band_accum
// PURPOSE
//  Downstream consumer of wrap_FFT. Takes the FFT magnitude stream (data, output_index,
//  valid/ready), sums bins into NUM_BANDS linear bands per frame, then scales and saturates
//  each sum to a LED column height. Streams band levels to the RainbowMatrix column driver.
// PARAMETERS
//  DATA_W      16  width of FFT magnitude input
//  IDX_W        8  width of bin index (256-point FFT)
//  NUM_BANDS   16  number of output bands / matrix columns
//  BIN_SHIFT    3  log2(bins per band); bins 0..(NUM_BANDS<<BIN_SHIFT)-1 used, rest dropped
//  LEVEL_SHIFT 11  right shift from band sum to level
//  LEVEL_W      4  level width; level saturates at 2**LEVEL_W-1
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 synchronous, active-high reset
//  data_in      in   DATA_W            FFT bin magnitude (unsigned)
//  index_in     in   IDX_W             bin index (wrap_FFT output_index)
//  data_in_valid in  1                 input beat valid
//  data_in_ready out 1                 block accepts a beat (drives wrap_FFT slave_ready)
//  band_valid   out  1                 band_idx/band_level valid
//  band_ready   in   1                 matrix driver accepts band
//  band_idx     out  log2(NUM_BANDS)   band (column) number
//  band_level   out  LEVEL_W           column height
//  frame_done   out  1                 1-cycle pulse after last band accepted
// BEHAVIOUR
//  - Reset: state=ACCUM, all accumulators 0, band_valid=0, band_idx=0, band_level=0,
//    frame_done=0, data_in_ready=0 while rst high. Reset mid-EMIT aborts frame; nothing emitted.
//  - Beat accepted when data_in_valid & data_in_ready. data_in_ready = (state==ACCUM) & ~rst.
//  - ACCUM: accepted beat with index_in < NUM_BANDS<<BIN_SHIFT adds data_in to
//    acc[index_in>>BIN_SHIFT] (width DATA_W+BIN_SHIFT, cannot overflow). Higher bins accepted and dropped.
//  - index_in==0 starts a new frame: acc[0]<=data_in, all other acc<=0, same cycle (restart
//    even mid-frame; out-of-order indices otherwise summed as given).
//  - Accepting index_in==(NUM_BANDS<<BIN_SHIFT)-1 -> EMIT next cycle; that beat is summed first.
//  - EMIT: band_valid=1, band_idx starts at 0; band_level = min(acc[band_idx]>>LEVEL_SHIFT,
//    2**LEVEL_W-1), registered, stable while band_valid & ~band_ready. On handshake band_idx++
//    next cycle, no bubbles. Handshake on band NUM_BANDS-1 -> ACCUM, band_valid=0, band_idx=0,
//    frame_done=1 for exactly one cycle. Min EMIT length NUM_BANDS cycles; input stalled throughout.
//  - Accumulators are not cleared on EMIT exit; clearing happens only at index 0.
// CONFIGURATION
//  PEAK_DECAY_EN defined: per-band peak register pk[b] (LEVEL_W, reset 0). On handshake of
//    band b: pk[b] <= max(lvl, pk[b]-(pk[b]!=0)); band_level presents that same value
//    (decays 1 step/frame, jumps up instantly).
//  PEAK_DECAY_EN undefined: no peak registers; band_level = scaled/saturated level only.
// STRUCTURE
//  - Shared package fft_band_pkg: state encoding (ACCUM, EMIT), derived constants
//    ACC_W=DATA_W+BIN_SHIFT, BAND_W=$clog2(NUM_BANDS), LAST_BIN=(NUM_BANDS<<BIN_SHIFT)-1.
//  - One sub-module band_level_scale: combinational shift + saturate (+ peak-decay compare
//    when PEAK_DECAY_EN); instantiated once on the band_idx-selected accumulator.
// TESTING
//  1 Bins 0..255 all 16'd256, band_ready=1 -> 16 bands, each level 1 (sum 2048>>11),
//    band_idx 0..15 consecutive, frame_done pulse once, data_in_ready low during EMIT.
//  2 Bins 8..15 =16'hFFFF, others 0 -> band 1 level 15 (saturated), all other bands 0.
//  3 band_ready toggled 1-of-3 cycles in EMIT -> idx/level held stable while stalled,
//    no band skipped or repeated, data_in_ready stays 0 until frame_done.
//  4 Send bins 0..60 then index 0 again, then full frame of 16'd4096 -> levels all 16
//    (saturated to 15), no residue from partial frame.
//  5 Assert rst for 1 cycle at band_idx=5 in EMIT -> next cycle band_valid=0, band_idx=0,
//    no frame_done; following full frame emits normally from band 0.
//  6 PEAK_DECAY_EN: frame A band 0 level 15, then frames of zeros -> band 0 emits 14,13,12...
//    to 0; without macro -> 15 then 0.

Source files
------------

// File: rtl/fft_band_accum_pkg.sv
// Shared constants, types and state encoding for the FFT band accumulator.
// Optional feature macro: PEAK_DECAY_EN.
package fft_band_pkg;

  localparam int DATA_W      = 16;
  localparam int IDX_W       = 8;
  localparam int NUM_BANDS   = 16;
  localparam int BIN_SHIFT   = 3;
  localparam int LEVEL_SHIFT = 11;
  localparam int LEVEL_W     = 4;

  localparam int ACC_W    = DATA_W + BIN_SHIFT;
  localparam int BAND_W   = $clog2(NUM_BANDS);
  localparam int LAST_BIN = (NUM_BANDS << BIN_SHIFT) - 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LAST_BIN);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [ACC_W-1:0]   acc_t;
  typedef logic [BAND_W-1:0]  band_t;
  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

endpackage

// File: rtl/fft_band_accum_if.sv
// Handshake bundles: FFT magnitude stream in, band level stream out.
// Optional feature macro: PEAK_DECAY_EN (no effect on these bundles).
interface fft_mag_if;
  import fft_band_pkg::*;

  data_t data_in;
  idx_t  index_in;
  logic  data_in_valid;
  logic  data_in_ready;

  modport master (
    output data_in, index_in, data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in, index_in, data_in_valid,
    output data_in_ready
  );
endinterface

interface band_if;
  import fft_band_pkg::*;

  logic   band_valid;
  logic   band_ready;
  band_t  band_idx;
  level_t band_level;
  logic   frame_done;

  modport master (
    output band_valid, band_idx, band_level, frame_done,
    input  band_ready
  );

  modport slave (
    input  band_valid, band_idx, band_level, frame_done,
    output band_ready
  );
endinterface

// File: rtl/fft_band_accum_scale.sv
// Band sum to column height: shift, saturate, optional peak-hold decay.
// Optional feature macro: PEAK_DECAY_EN.
module band_level_scale
  import fft_band_pkg::*;
(
  input  acc_t   acc_i,
`ifdef PEAK_DECAY_EN
  input  level_t pk_i,
`endif
  output level_t level_o
);

  logic   sat;
  level_t lvl;

  always_comb begin
    sat = |(acc_i >> (LEVEL_SHIFT + LEVEL_W));
    lvl = sat ? '1 : level_t'(acc_i >> LEVEL_SHIFT);
  end

`ifdef PEAK_DECAY_EN
  level_t decayed;

  // Peak falls one step per frame but follows a louder level at once.
  always_comb begin
    decayed = pk_i - level_t'(pk_i != '0);
    level_o = (lvl > decayed) ? lvl : decayed;
  end
`else
  assign level_o = lvl;
`endif

endmodule

// File: rtl/fft_band_accum.sv
// Sums FFT bins into linear bands per frame and streams saturated column heights.
// Optional feature macro: PEAK_DECAY_EN (per-band peak hold with decay).
module fft_band_accum
  import fft_band_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  fft_mag_if.slave mag,
  band_if.master   band
);

  state_e state_q, state_d;
  acc_t   acc_q [NUM_BANDS];
  acc_t   acc_d [NUM_BANDS];
  band_t  idx_q, idx_d;
  logic   valid_q, valid_d;
  logic   done_q, done_d;
  level_t level_q, level_d;
  level_t scaled;
  logic   accept;
  logic   hs;
  band_t  bin_band;

`ifdef PEAK_DECAY_EN
  level_t pk_q [NUM_BANDS];
  level_t pk_d [NUM_BANDS];
`endif

  assign mag.data_in_ready = (state_q == ACCUM) & ~rst;

  assign accept   = mag.data_in_valid & mag.data_in_ready;
  assign hs       = valid_q & band.band_ready;
  assign bin_band = band_t'(mag.index_in >> BIN_SHIFT);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef PEAK_DECAY_EN
    pk_d    = pk_q;
`endif
    if (accept) begin
      if (mag.index_in == '0) begin
        for (int b = 0; b < NUM_BANDS; b++)
          acc_d[b] = '0;
        acc_d[0] = acc_t'(mag.data_in);
      end else if (mag.index_in <= LAST_IDX) begin
        acc_d[bin_band] = acc_q[bin_band]
                        + acc_t'(mag.data_in);
      end
      if (mag.index_in == LAST_IDX) begin
        state_d = EMIT;
        valid_d = 1'b1;
        idx_d   = '0;
      end
    end
    if (hs) begin
`ifdef PEAK_DECAY_EN
      pk_d[idx_q] = level_q;
`endif
      if (idx_q == LAST_BAND) begin
        state_d = ACCUM;
        valid_d = 1'b0;
        idx_d   = '0;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Level is computed for the band presented next cycle, so it is registered.
  band_level_scale u_scale (
    .acc_i   (acc_d[idx_d]),
`ifdef PEAK_DECAY_EN
    .pk_i    (pk_d[idx_d]),
`endif
    .level_o (scaled)
  );

  assign level_d = valid_d ? scaled : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      for (int b = 0; b < NUM_BANDS; b++)
        acc_q[b] <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      level_q <= '0;
`ifdef PEAK_DECAY_EN
      for (int b = 0; b < NUM_BANDS; b++)
        pk_q[b] <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      level_q <= level_d;
`ifdef PEAK_DECAY_EN
      pk_q    <= pk_d;
`endif
    end
  end

  assign band.band_valid = valid_q;
  assign band.band_idx   = idx_q;
  assign band.band_level = level_q;
  assign band.frame_done = done_q;

endmodule
